// File: rtl/fsm12bit_pkg.sv
// fsm12bit_pkg: shared state type, command encodings and FSM load constant
package fsm12bit_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;
  localparam logic [2:0] CMD_LOAD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b100;
  localparam logic [2:0] CMD_ADD = 3'b101;
  localparam logic [2:0] CMD_SHR = 3'b110;
  localparam logic [2:0] CMD_SHL = 3'b111;
  localparam logic [11:0] FSM_LOAD_VALUE = 12'd588;
endpackage

// File: rtl/fsm12bit_step_sel.sv
// fsm12bit_step_sel: greedy choice of the next shift/add/sub command from shadow and target
module fsm12bit_step_sel import fsm12bit_pkg::*; #(
  parameter int MAX_STEP = 15,
  parameter bit ALLOW_SHIFT = 1'b1
) (
  input  logic [11:0] s,
  input  logic [11:0] t,
  output logic        mode,
  output logic        direction,
  output logic [3:0]  value,
  output logic [11:0] next_s
);
  logic [12:0] s13, t13, sl, sr, diff;
  logic shl, shr, add;
  logic [3:0] v;
  logic [2:0] cmd;
  always_comb begin
    s13 = {1'b0, s};
    t13 = {1'b0, t};
    sl = {s, 1'b0};
    sr = {2'b00, s[11:1]};
    shl = ALLOW_SHIFT && s != 12'd0 && !s[11] && sl <= t13;
    shr = ALLOW_SHIFT && sr >= t13 && s13 > t13;
    add = t13 > s13;
    diff = add ? t13 - s13 : s13 - t13;
    v = diff > 13'(MAX_STEP) ? 4'(MAX_STEP) : diff[3:0];
    cmd = shl ? CMD_SHL : shr ? CMD_SHR : add ? CMD_ADD : CMD_SUB;
    mode = cmd[1];
    direction = cmd[0];
    value = cmd[1] ? 4'd0 : v;
    next_s = shl ? sl[11:0] : shr ? sr[11:0] : add ? s + {8'd0, v} : s - {8'd0, v};
  end
endmodule

// File: rtl/fsm12bit_cmd_seq.sv
// fsm12bit_cmd_seq: drives the fsm12bit command interface to reach a target, tracking a shadow value
module fsm12bit_cmd_seq import fsm12bit_pkg::*; #(
  parameter logic [11:0] LOAD_VALUE = FSM_LOAD_VALUE,
  parameter int MAX_STEP = 15,
  parameter bit ALLOW_SHIFT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] target,
  input  logic        stall,
  output logic        enable,
  output logic        check,
  output logic        mode,
  output logic        direction,
  output logic [3:0]  value,
  output logic        busy,
  output logic        done,
  output logic [11:0] shadow,
  output logic [7:0]  step_count
);
  state_t state;
  logic [11:0] tgt, next_s;
  logic [3:0] sel_value;
  logic sel_mode, sel_dir;
  logic [2:0] cmd;
  logic [7:0] count_inc;
  fsm12bit_step_sel #(.MAX_STEP(MAX_STEP), .ALLOW_SHIFT(ALLOW_SHIFT)) u_sel (
    .s(shadow),
    .t(tgt),
    .mode(sel_mode),
    .direction(sel_dir),
    .value(sel_value),
    .next_s(next_s)
  );
  always_comb begin
    busy = state == LOAD || state == STEP;
    done = state == DONE;
    enable = busy && !stall;
    cmd = state == STEP ? {1'b1, sel_mode, sel_dir} : CMD_LOAD;
    check = cmd[2];
    mode = cmd[1];
    direction = cmd[0];
    value = state == STEP ? sel_value : 4'd0;
    count_inc = step_count + {7'd0, step_count != 8'hff};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      shadow <= 12'd0;
      tgt <= 12'd0;
      step_count <= 8'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tgt <= target;
          step_count <= 8'd0;
          state <= LOAD;
        end
        LOAD: if (!stall) begin
          shadow <= LOAD_VALUE;
          step_count <= count_inc;
          state <= LOAD_VALUE == tgt ? DONE : STEP;
        end
        STEP: if (!stall) begin
          shadow <= next_s;
          step_count <= count_inc;
          if (next_s == tgt) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsm12bit_cmd_seq.sv
// tb_fsm12bit_cmd_seq: directed self-checking bench with a behavioural fsm12bit model per instance
module tb_fsm12bit_cmd_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, start_b = 1'b0, stall = 1'b0, stall_b = 1'b0;
  logic [11:0] target = 12'd0;
  logic enable, check, mode, direction, busy, done;
  logic [3:0] value;
  logic [11:0] shadow;
  logic [7:0] step_count;
  logic enable_b, check_b, mode_b, direction_b, busy_b, done_b;
  logic [3:0] value_b;
  logic [11:0] shadow_b;
  logic [7:0] step_count_b;
  logic [11:0] fa = 12'd0, fb = 12'd0;
  logic tracking = 1'b0;
  int n_assert = 0, n_fail = 0;
  int c;

  always #5 clock = ~clock;

  fsm12bit_cmd_seq dut (
    .clock(clock), .reset(reset), .start(start), .target(target), .stall(stall),
    .enable(enable), .check(check), .mode(mode), .direction(direction), .value(value),
    .busy(busy), .done(done), .shadow(shadow), .step_count(step_count)
  );

  fsm12bit_cmd_seq #(.ALLOW_SHIFT(1'b0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .target(target), .stall(stall_b),
    .enable(enable_b), .check(check_b), .mode(mode_b), .direction(direction_b), .value(value_b),
    .busy(busy_b), .done(done_b), .shadow(shadow_b), .step_count(step_count_b)
  );

  // Reference fsm12bit register driven only by each sequencer's command interface
  always @(posedge clock) begin
    if (reset) begin
      fa <= 12'd0;
      fb <= 12'd0;
    end else begin
      if (enable)
        fa <= !check ? 12'd588 : !mode ? (direction ? fa + 12'(value) : fa - 12'(value))
                                       : (direction ? fa << 1 : fa >> 1);
      if (enable_b)
        fb <= !check_b ? 12'd588 : !mode_b ? (direction_b ? fb + 12'(value_b) : fb - 12'(value_b))
                                           : (direction_b ? fb << 1 : fb >> 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) if (tracking) begin
    chk("track_a", {20'd0, shadow}, {20'd0, fa});
    chk("track_b", {20'd0, shadow_b}, {20'd0, fb});
  end

  task automatic run(input logic [11:0] tg, input int steps, input logic [11:0] exp_s);
    @(negedge clock);
    target = tg;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    target = 12'hABC;
    c = 1;
    while (!done && c < 300) begin
      @(negedge clock);
      c++;
    end
    chk("done_latency", c, steps + 1);
    chk("step_count", {24'd0, step_count}, steps);
    chk("shadow", {20'd0, shadow}, {20'd0, exp_s});
    @(negedge clock);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("busy_after", {31'd0, busy}, 0);
  endtask

  initial begin
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_enable", {31'd0, enable}, 0);
    chk("rst_cmd", {28'd0, check, mode, direction, 1'b0}, 0);
    chk("rst_value", {28'd0, value}, 0);
    chk("rst_shadow", {20'd0, shadow}, 0);
    chk("rst_count", {24'd0, step_count}, 0);
    @(negedge clock);
    reset = 1'b0;
    tracking = 1'b1;
    run(12'd588, 1, 12'd588);
    @(negedge clock);
    target = 12'd600;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("load_enable", {31'd0, enable}, 1);
    chk("load_check", {31'd0, check}, 0);
    chk("load_busy", {31'd0, busy}, 1);
    @(negedge clock);
    chk("add_cmd", {29'd0, check, mode, direction}, 3'b101);
    chk("add_value", {28'd0, value}, 12);
    chk("add_shadow_pre", {20'd0, shadow}, 588);
    @(negedge clock);
    chk("600_done", {31'd0, done}, 1);
    chk("600_value_idle", {28'd0, value}, 0);
    chk("600_count", {24'd0, step_count}, 2);
    chk("600_shadow", {20'd0, shadow}, 600);
    run(12'd700, 9, 12'd700);
    run(12'd0, 11, 12'd0);
    run(12'd4095, 120, 12'd4095);
    @(negedge clock);
    target = 12'd0;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    c = 1;
    while (!done_b && c < 300) begin
      @(negedge clock);
      c++;
    end
    chk("b_latency", c, 42);
    chk("b_count", {24'd0, step_count_b}, 41);
    chk("b_shadow", {20'd0, shadow_b}, 0);
    chk("b_a_ignored", {31'd0, busy}, 0);
    @(negedge clock);
    target = 12'd700;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("stall_pre_shadow", {20'd0, shadow}, 603);
    stall = 1'b1;
    #1;
    chk("stall_enable", {31'd0, enable}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_shadow", {20'd0, shadow}, 603);
      chk("stall_hold_cmd", {29'd0, check, mode, direction}, 3'b101);
      chk("stall_hold_en", {31'd0, enable}, 0);
    end
    stall = 1'b0;
    #1;
    chk("unstall_enable", {31'd0, enable}, 1);
    c = 0;
    while (!done && c < 300) begin
      @(negedge clock);
      c++;
    end
    chk("stall_latency", c, 7);
    chk("stall_count", {24'd0, step_count}, 9);
    chk("stall_result", {20'd0, shadow}, 700);
    @(negedge clock);
    target = 12'd4095;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("pre_reset_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_shadow", {20'd0, shadow}, 0);
    chk("mid_rst_enable", {31'd0, enable}, 0);
    chk("mid_rst_count", {24'd0, step_count}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_done", {31'd0, done}, 0);
      @(negedge clock);
    end
    chk("mid_rst_idle", {31'd0, busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
